intersection_vip_night: RTL and testbench

- Two-approach traffic-light controller (approach 0 and approach 1), each with a car signal head and a pedestrian head.
- Runs a fixed day cycle and a flashing-yellow night mode selected by an ambient light sensor.
- At night, per-approach traffic-camera demand gives a green to the approach with waiting cars.
- A VIP request forces green for one approach and overrides day and night operation.

---
 rtl/intersection_vip_night_pkg.sv | 54 +++++
 rtl/intersection_vip_night_night_detector.sv | 34 +++
 rtl/intersection_vip_night.sv | 106 ++++++++++
 tb/tb_intersection_vip_night.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/intersection_vip_night_pkg.sv
// intersection_vip_night_pkg: shared state codes, head encodings, timing defaults and output decode.
package intersection_vip_night_pkg;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_G0    = 4'd1;
    localparam logic [3:0] S_L0    = 4'd2;
    localparam logic [3:0] S_Y0    = 4'd3;
    localparam logic [3:0] S_AR0   = 4'd4;
    localparam logic [3:0] S_G1    = 4'd5;
    localparam logic [3:0] S_L1    = 4'd6;
    localparam logic [3:0] S_Y1    = 4'd7;
    localparam logic [3:0] S_AR1   = 4'd8;
    localparam logic [3:0] S_FLASH = 4'd9;
    localparam logic [3:0] S_NG0   = 4'd10;
    localparam logic [3:0] S_NG1   = 4'd11;
    localparam logic [3:0] S_VG0   = 4'd12;
    localparam logic [3:0] S_VG1   = 4'd13;

    localparam logic [3:0] CAR_RED  = 4'b1000;
    localparam logic [3:0] CAR_YEL  = 4'b0100;
    localparam logic [3:0] CAR_LEFT = 4'b0010;
    localparam logic [3:0] CAR_GRN  = 4'b0001;
    localparam logic [3:0] CAR_OFF  = 4'b0000;

    localparam logic [1:0] WALK_RED = 2'b10;
    localparam logic [1:0] WALK_GO  = 2'b01;
    localparam logic [1:0] WALK_OFF = 2'b00;

    localparam int DEF_GREEN_T    = 30;
    localparam int DEF_LEFT_T     = 10;
    localparam int DEF_YELLOW_T   = 5;
    localparam int DEF_ALLRED_T   = 3;
    localparam int DEF_BLINK_T    = 5;
    localparam int DEF_NIGHT_TH   = 50;
    localparam int DEF_DEBOUNCE_T = 8;

    function automatic logic on_b(input logic [3:0] s);
        return s inside {S_G1, S_L1, S_Y1, S_AR1, S_NG1, S_VG1};
    endfunction

    // Returns {car0, walk0, car1, walk1}; lit selects the flashing-yellow phase.
    function automatic logic [11:0] heads(input logic [3:0] s, input logic lit);
        logic [3:0] c;
        logic [1:0] w;
        c = (s inside {S_G0, S_G1, S_NG0, S_NG1, S_VG0, S_VG1}) ? CAR_GRN :
            (s inside {S_L0, S_L1}) ? CAR_LEFT :
            (s inside {S_Y0, S_Y1}) ? CAR_YEL : CAR_RED;
        w = (s inside {S_G0, S_G1, S_NG0, S_NG1}) ? WALK_GO : WALK_RED;
        if (s == S_FLASH)
            return {lit ? CAR_YEL : CAR_OFF, WALK_OFF, lit ? CAR_YEL : CAR_OFF, WALK_OFF};
        return on_b(s) ? {CAR_RED, w, c, WALK_RED} : {c, WALK_RED, CAR_RED, w};
    endfunction

endpackage

// File: rtl/intersection_vip_night_night_detector.sv
// night_detector: debounced ambient-light comparator producing the night flag.
module night_detector #(
    parameter int NIGHT_TH   = 50,
    parameter int DEBOUNCE_T = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_light,
    output logic       o_night
);
    localparam int CW = $clog2(DEBOUNCE_T + 1);

    logic [CW-1:0] r_cnt;
    logic          r_night;
    logic          w_dark;

    assign w_dark  = i_light < 10'(NIGHT_TH);
    assign o_night = r_night;

    // Counts consecutive samples that disagree with the current flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_night <= 1'b0;
        end else if (w_dark == r_night) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_T - 1)) begin
            r_cnt   <= '0;
            r_night <= w_dark;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/intersection_vip_night.sv
// intersection_vip_night: two-approach light controller with day cycle, night flash/demand and VIP override.
module intersection_vip_night
    import intersection_vip_night_pkg::*;
#(
    parameter int GREEN_T    = DEF_GREEN_T,
    parameter int LEFT_T     = DEF_LEFT_T,
    parameter int YELLOW_T   = DEF_YELLOW_T,
    parameter int ALLRED_T   = DEF_ALLRED_T,
    parameter int BLINK_T    = DEF_BLINK_T,
    parameter int NIGHT_TH   = DEF_NIGHT_TH,
    parameter int DEBOUNCE_T = DEF_DEBOUNCE_T
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [1:0] vip_slide,
    input  logic [9:0] light_sensor,
    input  logic [1:0] traffic_camera,
    output logic [3:0] car_traffic_0,
    output logic [1:0] walk_traffic_0,
    output logic [3:0] car_traffic_1,
    output logic [1:0] walk_traffic_1
);
    localparam logic [7:0] G_END = 8'(GREEN_T - 1);
    localparam logic [7:0] L_END = 8'(LEFT_T - 1);
    localparam logic [7:0] Y_END = 8'(YELLOW_T - 1);
    localparam logic [7:0] A_END = 8'(ALLRED_T - 1);
    localparam logic [7:0] B_HALF = 8'(BLINK_T);
    localparam logic [7:0] B_END = 8'(2 * BLINK_T - 1);

    logic [3:0]  r_state;
    logic [7:0]  r_cnt;
    logic [11:0] r_heads;
    logic [3:0]  w_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_night;
    logic        w_d;
    logic        w_vip;
    logic        w_vd;
    logic        w_both;
    logic        w_cut;
    logic [3:0]  w_y;
    logic [3:0]  w_vg;
    logic [3:0]  w_ng;
    logic [3:0]  w_other_g;
    logic [3:0]  w_after;

    night_detector #(.NIGHT_TH(NIGHT_TH), .DEBOUNCE_T(DEBOUNCE_T)) u_night (
        .clk     (clk),
        .rst     (rstn),
        .i_light (light_sensor),
        .o_night (w_night)
    );

    assign w_d       = on_b(r_state);
    assign w_vip     = |vip_slide;
    assign w_vd      = ~vip_slide[0];
    assign w_both    = traffic_camera == 2'b11;
    assign w_cut     = w_night && !w_both;
    assign w_y       = w_d ? S_Y1 : S_Y0;
    assign w_vg      = w_vd ? S_VG1 : S_VG0;
    assign w_ng      = traffic_camera[0] ? S_NG0 : S_NG1;
    assign w_other_g = w_d ? S_G0 : S_G1;
    // Where to go once an all-red clearance has finished.
    assign w_after   = w_vip ? w_vg : (!w_night || w_both) ? w_other_g :
                       (traffic_camera == 2'b00) ? S_FLASH : w_ng;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:       w_nxt = S_G0;
            S_G0, S_G1:   w_nxt = w_vip ? ((w_vd == w_d) ? w_vg : w_y) : w_cut ? w_y :
                                  (r_cnt == G_END) ? (w_d ? S_L1 : S_L0) : r_state;
            S_L0, S_L1:   w_nxt = (w_vip || w_cut || r_cnt == L_END) ? w_y : r_state;
            S_Y0, S_Y1:   w_nxt = (r_cnt == Y_END) ? (w_d ? S_AR1 : S_AR0) : r_state;
            S_AR0, S_AR1: w_nxt = (r_cnt == A_END) ? w_after : r_state;
            S_FLASH:      w_nxt = w_vip ? w_vg : !w_night ? S_AR1 : w_both ? S_G0 :
                                  (traffic_camera == 2'b00) ? S_FLASH : w_ng;
            // Night green: approach 0 hands straight to day G0, approach 1 clears first.
            S_NG0, S_NG1: w_nxt = w_vip ? ((w_vd == w_d) ? w_vg : w_y) :
                                  !w_night ? (w_d ? w_y : S_G0) :
                                  (!traffic_camera[w_d] && r_cnt >= G_END) ? w_y : r_state;
            S_VG0, S_VG1: w_nxt = (w_vip && w_vd == w_d) ? r_state : w_y;
            default:      w_nxt = S_IDLE;
        endcase
        if (!start) w_nxt = S_IDLE;
    end

    assign w_cnt_nxt = (w_nxt != r_state || w_nxt == S_IDLE) ? 8'd0 :
                       (r_state == S_FLASH && r_cnt == B_END) ? 8'd0 :
                       (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_heads <= heads(S_IDLE, 1'b0);
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_heads <= heads(w_nxt, w_cnt_nxt < B_HALF);
        end
    end

    assign {car_traffic_0, walk_traffic_0, car_traffic_1, walk_traffic_1} = r_heads;
endmodule

// File: tb/tb_intersection_vip_night.sv
// tb_intersection_vip_night: directed plus randomized checking against a phase-level reference model.
module tb_intersection_vip_night;
    localparam int GREEN_T = 30, LEFT_T = 10, YELLOW_T = 5, ALLRED_T = 3;
    localparam int BLINK_T = 5, NIGHT_TH = 50, DEBOUNCE_T = 8;
    localparam int K_IDLE = 0, K_G = 1, K_L = 2, K_Y = 3, K_AR = 4, K_FL = 5, K_NG = 6, K_VG = 7;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       start = 1'b1;
    logic [1:0] vip = 2'b00;
    logic [9:0] light = 10'd200;
    logic [1:0] cam = 2'b00;
    logic [3:0] car0, car1;
    logic [1:0] walk0, walk1;

    int  checks = 0;
    int  fails = 0;
    bit  chk_en = 0;
    int  k = K_IDLE, a = 0, t = 0, run = 0;
    bit  mnight = 0;

    intersection_vip_night dut (
        .clk(clk), .rstn(rstn), .start(start), .vip_slide(vip), .light_sensor(light),
        .traffic_camera(cam), .car_traffic_0(car0), .walk_traffic_0(walk0),
        .car_traffic_1(car1), .walk_traffic_1(walk1)
    );

    always #5 clk = ~clk;

    // Reference model: phase kind + served approach + elapsed cycles in that phase.
    always @(posedge clk) begin : model
        int nk, na, vw;
        bit v;
        if (rstn) begin
            k = K_IDLE; a = 0; t = 0; run = 0; mnight = 0;
        end else begin
            v = |vip;
            vw = vip[0] ? 0 : 1;
            nk = k; na = a;
            if (!start) begin
                nk = K_IDLE; na = 0;
            end else begin
                case (k)
                    K_IDLE: begin nk = K_G; na = 0; end
                    K_G: if (v) nk = (vw == a) ? K_VG : K_Y;
                         else if (mnight && cam != 2'b11) nk = K_Y;
                         else if (t + 1 == GREEN_T) nk = K_L;
                    K_L: if (v || (mnight && cam != 2'b11) || t + 1 == LEFT_T) nk = K_Y;
                    K_Y: if (t + 1 == YELLOW_T) nk = K_AR;
                    K_AR: if (t + 1 == ALLRED_T) begin
                        if (v) begin nk = K_VG; na = vw; end
                        else if (!mnight || cam == 2'b11) begin nk = K_G; na = 1 - a; end
                        else if (cam == 2'b00) nk = K_FL;
                        else begin nk = K_NG; na = cam[0] ? 0 : 1; end
                    end
                    K_FL: if (v) begin nk = K_VG; na = vw; end
                          else if (!mnight) begin nk = K_AR; na = 1; end
                          else if (cam == 2'b11) begin nk = K_G; na = 0; end
                          else if (cam != 2'b00) begin nk = K_NG; na = cam[0] ? 0 : 1; end
                    K_NG: if (v) nk = (vw == a) ? K_VG : K_Y;
                          else if (!mnight) nk = (a == 0) ? K_G : K_Y;
                          else if (!cam[a] && t + 1 >= GREEN_T) nk = K_Y;
                    K_VG: if (!(v && vw == a)) nk = K_Y;
                    default: nk = K_IDLE;
                endcase
            end
            t = (nk != k || na != a || nk == K_IDLE) ? 0 : t + 1;
            k = nk; a = na;
            if ((light < NIGHT_TH) == mnight) run = 0;
            else begin
                run++;
                if (run == DEBOUNCE_T) begin mnight = !mnight; run = 0; end
            end
        end
    end

    function automatic logic [11:0] expect_heads();
        logic [3:0] c, f;
        logic [1:0] wo;
        if (k == K_IDLE) return {4'b1000, 2'b10, 4'b1000, 2'b10};
        if (k == K_FL) begin
            f = ((t / BLINK_T) % 2 == 0) ? 4'b0100 : 4'b0000;
            return {f, 2'b00, f, 2'b00};
        end
        c = (k == K_L) ? 4'b0010 : (k == K_Y) ? 4'b0100 : (k == K_AR) ? 4'b1000 : 4'b0001;
        wo = (k == K_G || k == K_NG) ? 2'b01 : 2'b10;
        return (a == 0) ? {c, 2'b10, 4'b1000, wo} : {4'b1000, wo, c, 2'b10};
    endfunction

    function automatic bit busy(input logic [3:0] c);
        return c != 4'b1000 && c != 4'b0000;
    endfunction

    always @(negedge clk) begin : compare
        logic [11:0] got, exp;
        if (chk_en) begin
            got = {car0, walk0, car1, walk1};
            exp = expect_heads();
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL heads t=%0t got=%b exp=%b (kind=%0d appr=%0d)", $time, got, exp, k, a);
            end
            checks++;
            if (busy(car0) && busy(car1) && !(car0 == 4'b0100 && car1 == 4'b0100 && walk0 == 2'b00 && walk1 == 2'b00)) begin
                fails++;
                $display("FAIL safety t=%0t car0=%b car1=%b walk0=%b walk1=%b", $time, car0, car1, walk0, walk1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [11:0] exp);
        checks++;
        if ({car0, walk0, car1, walk1} !== exp) begin
            fails++;
            $display("FAIL %s got=%b required=%b", name, {car0, walk0, car1, walk1}, exp);
        end
    endtask

    initial begin
        step(2);
        chk_en = 1;
        step(18);
        lit("reset", {4'b1000, 2'b10, 4'b1000, 2'b10});
        rstn = 0;
        step(1);  lit("g0_first", {4'b0001, 2'b10, 4'b1000, 2'b01});
        step(30); lit("l0", {4'b0010, 2'b10, 4'b1000, 2'b10});
        step(10); lit("y0", {4'b0100, 2'b10, 4'b1000, 2'b10});
        step(5);  lit("ar0", {4'b1000, 2'b10, 4'b1000, 2'b10});
        step(3);  lit("g1", {4'b1000, 2'b01, 4'b0001, 2'b10});
        step(48); lit("g0_again", {4'b0001, 2'b10, 4'b1000, 2'b01});
        step(2);  vip = 2'b10;
        step(1);  lit("vip_trunc_y0", {4'b0100, 2'b10, 4'b1000, 2'b10});
        step(8);  lit("vg1", {4'b1000, 2'b10, 4'b0001, 2'b10});
        step(11); vip = 2'b00;
        step(60);
        light = 10; step(5); light = 100; step(20);
        light = 10; step(80);
        checks++;
        if (!(car0 == car1 && walk0 == 2'b00 && walk1 == 2'b00 && (car0 == 4'b0100 || car0 == 4'b0000))) begin
            fails++;
            $display("FAIL flash car0=%b car1=%b walk0=%b walk1=%b", car0, car1, walk0, walk1);
        end
        cam = 2'b01; step(10);
        cam = 2'b10; step(50);
        cam = 2'b00; step(60);
        cam = 2'b11; step(100);
        cam = 2'b00; step(30);
        light = 100; step(15);
        lit("day_after_night", {4'b0001, 2'b10, 4'b1000, 2'b01});
        vip = 2'b11;
        step(1);  lit("vip_both_vg0", {4'b0001, 2'b10, 4'b1000, 2'b10});
        vip = 2'b00; step(20);
        start = 0;
        step(1);  lit("start_low", {4'b1000, 2'b10, 4'b1000, 2'b10});
        start = 1; step(5);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 999) == 0);
            start = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0)
                case ($urandom_range(0, 3))
                    0: light = 10'd10;
                    1: light = 10'd49;
                    2: light = 10'd50;
                    default: light = 10'd200;
                endcase
            if ($urandom_range(0, 14) == 0) cam = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) vip = (vip != 2'b00) ? 2'b00 : 2'($urandom_range(1, 3));
        end
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
